// File: rtl/l2_mshr_alloc.sv
// MSHR allocator/retirer for the L2 Spandex controller: lowest-free-index
// allocation, completion-driven free, set-conflict lookup and event pulses.
module l2_mshr_alloc #(
  parameter int unsigned N_MSHR    = 4,
  parameter int unsigned MSHR_BITS = 2,
  parameter int unsigned SET_BITS  = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_req,
  input  logic [SET_BITS-1:0]  alloc_set,
  input  logic                 alloc_evict,
  output logic                 alloc_gnt,
  output logic [MSHR_BITS-1:0] alloc_idx,
  input  logic                 free_req,
  input  logic [MSHR_BITS-1:0] free_idx,
  input  logic [SET_BITS-1:0]  lookup_set,
  output logic                 lookup_hit,
  output logic [MSHR_BITS-1:0] lookup_hit_idx,
  output logic                 evict_busy,
  output logic                 add_mshr_entry,
  output logic                 incr_mshr_cnt,
  output logic [MSHR_BITS:0]   free_cnt,
  output logic                 full,
  output logic                 empty,
  output logic                 free_err
);

  localparam int unsigned CNT_W = MSHR_BITS + 1;

  logic [N_MSHR-1:0]   valid_q, valid_d;
  logic [N_MSHR-1:0]   evict_q, evict_d;
  logic [SET_BITS-1:0] set_q [N_MSHR];
  logic [SET_BITS-1:0] set_d [N_MSHR];
  logic [CNT_W-1:0]    free_cnt_q, free_cnt_d;
  logic                add_q, add_d;
  logic                incr_q, incr_d;
  logic                evict_busy_q, evict_busy_d;
  logic                free_err_q, free_err_d;
  logic                valid_free;
  logic                idx_found;

  assign full      = (free_cnt_q == '0);
  assign empty     = (free_cnt_q == CNT_W'(N_MSHR));
  assign alloc_gnt = alloc_req & ~full;
  assign valid_free = free_req & valid_q[free_idx];

  // Both the free-slot search and the lookup see only pre-edge state.
  always_comb begin
    alloc_idx = '0;
    idx_found = 1'b0;
    for (int unsigned i = 0; i < N_MSHR; i++) begin
      if (!valid_q[i] && !idx_found) begin
        alloc_idx = MSHR_BITS'(i);
        idx_found = 1'b1;
      end
    end
  end

  always_comb begin
    lookup_hit     = 1'b0;
    lookup_hit_idx = '0;
    for (int unsigned i = 0; i < N_MSHR; i++) begin
      if (valid_q[i] && set_q[i] == lookup_set && !lookup_hit) begin
        lookup_hit     = 1'b1;
        lookup_hit_idx = MSHR_BITS'(i);
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    evict_d = evict_q;
    set_d   = set_q;
    if (valid_free) begin
      valid_d[free_idx] = 1'b0;
      evict_d[free_idx] = 1'b0;
    end
    if (alloc_gnt) begin
      valid_d[alloc_idx] = 1'b1;
      evict_d[alloc_idx] = alloc_evict;
      set_d[alloc_idx]   = alloc_set;
    end
    free_cnt_d   = free_cnt_q - CNT_W'(alloc_gnt) + CNT_W'(valid_free);
    evict_busy_d = |(valid_d & evict_d);
    free_err_d   = free_err_q | (free_req & ~valid_q[free_idx]);
    add_d        = alloc_gnt;
    incr_d       = valid_free;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q      <= '0;
      evict_q      <= '0;
      set_q        <= '{default: '0};
      free_cnt_q   <= CNT_W'(N_MSHR);
      add_q        <= 1'b0;
      incr_q       <= 1'b0;
      evict_busy_q <= 1'b0;
      free_err_q   <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      evict_q      <= evict_d;
      set_q        <= set_d;
      free_cnt_q   <= free_cnt_d;
      add_q        <= add_d;
      incr_q       <= incr_d;
      evict_busy_q <= evict_busy_d;
      free_err_q   <= free_err_d;
    end
  end

  assign free_cnt       = free_cnt_q;
  assign add_mshr_entry = add_q;
  assign incr_mshr_cnt  = incr_q;
  assign evict_busy     = evict_busy_q;
  assign free_err       = free_err_q;

endmodule

// File: tb/tb_l2_mshr_alloc.sv
// Scoreboard bench for l2_mshr_alloc: a behavioural pool model queues the
// expected outputs per cycle; they are compared before and after the edge.
module tb_l2_mshr_alloc;

  localparam int unsigned N  = 4;
  localparam int unsigned MB = 2;
  localparam int unsigned SB = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          alloc_req;
  logic [SB-1:0] alloc_set;
  logic          alloc_evict;
  logic          alloc_gnt;
  logic [MB-1:0] alloc_idx;
  logic          free_req;
  logic [MB-1:0] free_idx;
  logic [SB-1:0] lookup_set;
  logic          lookup_hit;
  logic [MB-1:0] lookup_hit_idx;
  logic          evict_busy;
  logic          add_mshr_entry;
  logic          incr_mshr_cnt;
  logic [MB:0]   free_cnt;
  logic          full;
  logic          empty;
  logic          free_err;

  l2_mshr_alloc #(.N_MSHR(N), .MSHR_BITS(MB), .SET_BITS(SB)) dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_set(alloc_set), .alloc_evict(alloc_evict),
    .alloc_gnt(alloc_gnt), .alloc_idx(alloc_idx),
    .free_req(free_req), .free_idx(free_idx),
    .lookup_set(lookup_set), .lookup_hit(lookup_hit), .lookup_hit_idx(lookup_hit_idx),
    .evict_busy(evict_busy), .add_mshr_entry(add_mshr_entry), .incr_mshr_cnt(incr_mshr_cnt),
    .free_cnt(free_cnt), .full(full), .empty(empty), .free_err(free_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          gnt;
    logic [MB-1:0] idx;
    logic          hit;
    logic [MB-1:0] hit_idx;
    logic [MB:0]   cnt;
    logic          full;
    logic          empty;
    logic          add;
    logic          incr;
    logic          eb;
    logic          err;
  } exp_t;

  exp_t exp_q[$];

  bit            m_valid [N];
  bit            m_evict [N];
  logic [SB-1:0] m_set   [N];
  bit            m_err;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_evict[i] = 1'b0;
      m_set[i]   = '0;
    end
    m_err = 1'b0;
  endtask

  // Reset is held for one edge while an allocation is being requested.
  task automatic do_reset(input logic [SB-1:0] lset);
    rst = 1'b0; alloc_req = 1'b1; alloc_set = 9'h013; alloc_evict = 1'b1;
    free_req = 1'b0; free_idx = '0; lookup_set = lset;
    @(posedge clk); #1;
    rst = 1'b1; alloc_req = 1'b0; alloc_evict = 1'b0;
    model_clear();
    check_eq("rst_free_cnt", 32'(free_cnt), 32'(N));
    check_eq("rst_empty", 32'(empty), 32'd1);
    check_eq("rst_full", 32'(full), 32'd0);
    check_eq("rst_add", 32'(add_mshr_entry), 32'd0);
    check_eq("rst_incr", 32'(incr_mshr_cnt), 32'd0);
    check_eq("rst_evict_busy", 32'(evict_busy), 32'd0);
    check_eq("rst_free_err", 32'(free_err), 32'd0);
    check_eq("rst_lookup_hit", 32'(lookup_hit), 32'd0);
  endtask

  task automatic cycle(input logic req, input logic [SB-1:0] aset, input logic ev,
                       input logic fr, input logic [MB-1:0] fi, input logic [SB-1:0] lset);
    exp_t e, o;
    int unsigned nfree;
    bit vfree;
    alloc_req = req; alloc_set = aset; alloc_evict = ev;
    free_req = fr; free_idx = fi; lookup_set = lset;

    nfree = 0;
    for (int i = 0; i < N; i++) if (!m_valid[i]) nfree++;
    e.gnt = req && (nfree != 0);
    e.idx = '0;
    for (int i = N - 1; i >= 0; i--) if (!m_valid[i]) e.idx = MB'(i);
    e.hit = 1'b0; e.hit_idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (m_valid[i] && m_set[i] == lset) begin e.hit = 1'b1; e.hit_idx = MB'(i); end
    vfree = fr && m_valid[fi];
    if (fr && !m_valid[fi]) m_err = 1'b1;
    if (vfree) begin m_valid[fi] = 1'b0; m_evict[fi] = 1'b0; end
    if (e.gnt) begin m_valid[e.idx] = 1'b1; m_evict[e.idx] = ev; m_set[e.idx] = aset; end
    nfree = 0;
    e.eb = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!m_valid[i]) nfree++;
      if (m_valid[i] && m_evict[i]) e.eb = 1'b1;
    end
    e.cnt = (MB+1)'(nfree);
    e.full = (nfree == 0);
    e.empty = (nfree == N);
    e.add = e.gnt;
    e.incr = vfree;
    e.err = m_err;
    exp_q.push_back(e);

    @(negedge clk);
    o = exp_q.pop_front();
    check_eq("alloc_gnt", 32'(alloc_gnt), 32'(o.gnt));
    if (o.gnt) check_eq("alloc_idx", 32'(alloc_idx), 32'(o.idx));
    check_eq("lookup_hit", 32'(lookup_hit), 32'(o.hit));
    if (o.hit) check_eq("lookup_hit_idx", 32'(lookup_hit_idx), 32'(o.hit_idx));

    @(posedge clk); #1;
    check_eq("free_cnt", 32'(free_cnt), 32'(o.cnt));
    check_eq("full", 32'(full), 32'(o.full));
    check_eq("empty", 32'(empty), 32'(o.empty));
    check_eq("add_mshr_entry", 32'(add_mshr_entry), 32'(o.add));
    check_eq("incr_mshr_cnt", 32'(incr_mshr_cnt), 32'(o.incr));
    check_eq("evict_busy", 32'(evict_busy), 32'(o.eb));
    check_eq("free_err", 32'(free_err), 32'(o.err));
  endtask

  task automatic idle(input logic [SB-1:0] lset);
    cycle(1'b0, '0, 1'b0, 1'b0, '0, lset);
  endtask

  initial begin
    rst = 1'b0; alloc_req = 1'b0; alloc_set = '0; alloc_evict = 1'b0;
    free_req = 1'b0; free_idx = '0; lookup_set = '0;
    do_reset('0);

    // Fill the pool in index order
    for (int i = 0; i < 4; i++) cycle(1'b1, SB'(9'h010 + i), 1'b0, 1'b0, '0, '0);
    idle('0);
    check_eq("tp1_full", 32'(full), 32'd1);

    // Request while full, then free 2 and re-grant 2
    cycle(1'b1, 9'h055, 1'b0, 1'b0, '0, 9'h055);
    cycle(1'b0, '0, 1'b0, 1'b1, 2'd2, '0);
    cycle(1'b1, 9'h077, 1'b0, 1'b0, '0, 9'h077);
    check_eq("tp2_regrant_cnt", 32'(free_cnt), 32'd0);

    // Leave 0 and 1 valid, then alloc and free 0 together
    cycle(1'b0, '0, 1'b0, 1'b1, 2'd3, '0);
    cycle(1'b0, '0, 1'b0, 1'b1, 2'd2, '0);
    cycle(1'b1, 9'h030, 1'b0, 1'b1, 2'd0, '0);
    check_eq("tp3_cnt_stays", 32'(free_cnt), 32'd2);
    check_eq("tp3_both_pulses", 32'({add_mshr_entry, incr_mshr_cnt}), 32'd3);

    // Lookup visibility around allocation and free of idx 0
    cycle(1'b1, 9'h1A3, 1'b0, 1'b0, '0, 9'h1A3);
    idle(9'h1A3);
    cycle(1'b0, '0, 1'b0, 1'b1, 2'd0, 9'h1A3);
    idle(9'h1A3);

    // Eviction entry in idx 1, then double free of idx 1
    cycle(1'b0, '0, 1'b0, 1'b1, 2'd1, '0);
    cycle(1'b1, 9'h040, 1'b0, 1'b0, '0, '0);
    cycle(1'b1, 9'h041, 1'b1, 1'b0, '0, '0);
    check_eq("tp5_evict_busy", 32'(evict_busy), 32'd1);
    cycle(1'b0, '0, 1'b0, 1'b1, 2'd1, '0);
    cycle(1'b0, '0, 1'b0, 1'b1, 2'd1, '0);
    check_eq("tp5_free_err", 32'(free_err), 32'd1);

    // Three valid entries, then reset mid-operation
    cycle(1'b1, 9'h0EE, 1'b0, 1'b0, '0, '0);
    do_reset(9'h0EE);
    idle(9'h0EE);

    // Random traffic on a narrow set range to exercise conflicts
    for (int n = 0; n < 80; n++)
      cycle(1'($urandom_range(0, 1)), SB'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), MB'($urandom_range(0, N - 1)), SB'($urandom_range(0, 7)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/l2_mshr_alloc.md
Name: l2_mshr_alloc

Overview:
- MSHR allocator and retirer for the L2 Spandex controller.
- Drives the allocation and free side of the MSHR pool: picks a free entry index, records its set and eviction flag, and frees entries on transaction completion.
- Produces the per-cycle add/incr pulses, free count and set-conflict lookup used by the L2 control FSM and the L2 register block.

Parameters:
- N_MSHR, 4, number of MSHR entries (power of two, 2..16)
- MSHR_BITS, 2, log2(N_MSHR)
- SET_BITS, 9, width of the L2 set index stored per entry

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- alloc_req  in  1  request to allocate an entry this cycle
- alloc_set  in  SET_BITS  set index of the allocating request
- alloc_evict  in  1  allocation is an eviction (put) transaction
- alloc_gnt  out  1  allocation accepted this cycle (combinational)
- alloc_idx  out  MSHR_BITS  index granted (valid when alloc_gnt)
- free_req  in  1  retire entry free_idx
- free_idx  in  MSHR_BITS  entry to retire
- lookup_set  in  SET_BITS  set probed for conflict
- lookup_hit  out  1  some valid entry holds lookup_set (combinational)
- lookup_hit_idx  out  MSHR_BITS  lowest matching entry index
- evict_busy  out  1  registered: a valid eviction entry exists
- add_mshr_entry  out  1  registered one-cycle pulse: alloc accepted last cycle
- incr_mshr_cnt  out  1  registered one-cycle pulse: valid free accepted last cycle
- free_cnt  out  MSHR_BITS+1  number of invalid entries
- full  out  1  free_cnt == 0
- empty  out  1  free_cnt == N_MSHR
- free_err  out  1  sticky: free of an already-invalid entry

Behaviour:
- Reset (rst low at posedge, synchronous):
  - All valid/evict/set state cleared; free_cnt = N_MSHR; full = 0; empty = 1.
  - All pulses, evict_busy and free_err cleared.
  - Reset mid-operation discards all outstanding entries with no free pulses.
- Per-entry state: valid, evict, set[SET_BITS-1:0].
- Allocation:
  - alloc_gnt = alloc_req & ~full.
  - alloc_idx = lowest index with valid==0, taken from registered state.
  - On grant: entry valid<=1, set<=alloc_set, evict<=alloc_evict at the next edge.
  - alloc_req while full: no grant, no state change; the requester retries. There is no internal queue.
- Free:
  - free_req with valid[free_idx]==1: valid<=0 and evict<=0 at the next edge. The stored set is left stale.
  - free_req with valid[free_idx]==0: ignored; free_err<=1 (sticky until reset).
- Simultaneous alloc and free in one cycle:
  - Both are applied.
  - The freed index is never granted in the same cycle, because allocation uses the pre-edge valid vector.
  - free_cnt stays unchanged; both pulses fire next cycle.
- free_cnt:
  - Registered.
  - Next value = free_cnt − grant + valid_free, computed at MSHR_BITS+1 width.
  - Never exceeds N_MSHR and never goes below 0.
- Pulses:
  - add_mshr_entry <= alloc_gnt; incr_mshr_cnt <= valid_free.
  - One cycle wide, one cycle after the event, so an external counter driven by them tracks free_cnt with one-cycle lag.
- lookup_hit is combinational over the registered state only.
  - An entry granted this cycle is not visible until the next cycle.
  - An entry freed this cycle remains visible until the next cycle.
- evict_busy <= OR over (valid & evict) of the next state.
- full and empty decode the registered free_cnt.

Test Plan:
1. Reset, then alloc_req for 4 consecutive cycles with sets 0x10..0x13 -> alloc_idx 0,1,2,3 with alloc_gnt=1; free_cnt steps 4→0; full=1 after the 4th; add_mshr_entry pulses 4 times, each lagging by one cycle.
2. Full pool, alloc_req=1 -> alloc_gnt=0, state unchanged. Next, free_idx=2 -> incr_mshr_cnt pulse next cycle; next alloc grants idx 2.
3. Entries 0 and 1 valid, same cycle alloc_req and free_idx=0 -> grant idx 2 (not 0); free_cnt stays 2; both pulses high next cycle.
4. Alloc set 0x1A3 into idx 0, lookup_set=0x1A3 in the same cycle -> lookup_hit=0. Next cycle -> lookup_hit=1, lookup_hit_idx=0. After freeing idx 0 -> lookup_hit=0.
5. alloc_evict=1 into idx 1 -> evict_busy=1 next cycle; free idx 1 -> evict_busy=0 next cycle. Then free idx 1 again -> free_err=1, free_cnt unchanged, no incr pulse.
6. 3 entries valid, assert rst low for one cycle during an alloc_req -> free_cnt=4, empty=1, lookup_hit=0, no pulses, free_err=0.
